// File: rtl/mult32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult32_pkg
//  Description : Shared definitions for the sequential 32x32 multiplier:
//                FSM state encoding, operand width, iteration count and
//                iteration-counter width.
//  Revision    : 1.0  initial release
// ============================================================================
package mult32_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mult32_pkg
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
//  Module      : adder
//  Description : 32-bit ripple-carry adder/subtractor.
//                isSub=0 : sum = a + b
//                isSub=1 : sum = a - b (two's complement)
//  Ports       : a, b      - 32-bit operands
//                isSub     - select subtract
//                sum       - 32-bit result
//                overflow  - signed overflow of the operation
//  Revision    : 1.0  initial release
// ============================================================================
module adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        isSub,
    output logic [31:0] sum,
    output logic        overflow
);

    logic [32:0] w_c;
    logic [31:0] w_b;

    // Subtraction is a + ~b + 1: invert b and inject the +1 as carry-in.
    assign w_b    = b ^ {32{isSub}};
    assign w_c[0] = isSub;

    generate
        for (genvar i = 0; i < 32; i++) begin : g_bit
            assign sum[i]   = a[i] ^ w_b[i] ^ w_c[i];
            assign w_c[i+1] = (a[i] & w_b[i]) | (w_c[i] & (a[i] ^ w_b[i]));
        end
    endgenerate

    assign overflow = w_c[32] ^ w_c[31];

endmodule : adder
`default_nettype wire

// File: rtl/mult32_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mult32_seq
//  Description : Sequential shift-and-add 32x32 -> 64 multiplier.
//                One partial-product step per clock; a multiply takes
//                32 CALC cycles followed by a single DONE cycle.
//  Ports       : clk      - rising-edge clock
//                reset    - synchronous active-high reset
//                start    - request a multiply (accepted only while ready)
//                a, b     - multiplicand / multiplier, sampled on acceptance
//                ready    - idle and able to accept start
//                done     - one-cycle pulse, product valid
//                product  - 64-bit result register
//  Config      : `define MULT32_SIGNED_EN for two's-complement operands
//                (sign-magnitude around the unsigned core; same latency).
//  Revision    : 1.0  initial release
// ============================================================================
module mult32_seq #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    import mult32_pkg::*;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(ITER - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic               w_ovf_unused;
    logic [WIDTH:0]     w_hi_nxt;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_final;
    logic [WIDTH-1:0]   w_load_a;
    logic [WIDTH-1:0]   w_load_b;

    assign w_hi = r_prod[2*WIDTH-1:WIDTH];

    adder u_adder (
        .a        (w_hi),
        .b        (r_mcand),
        .isSub    (1'b0),
        .sum      (w_sum),
        .overflow (w_ovf_unused)
    );

    // The adder has no carry-out; recover it from the operand and sum MSBs.
    assign w_cout = (r_mcand[WIDTH-1] & w_hi[WIDTH-1]) |
                    ((r_mcand[WIDTH-1] | w_hi[WIDTH-1]) & ~w_sum[WIDTH-1]);

    assign w_hi_nxt = r_prod[0] ? {w_cout, w_sum} : {1'b0, w_hi};

    // {cout,sum,lo} shifted right by one: the low bit of the multiplier
    // just consumed drops off the bottom.
    assign w_step = {w_hi_nxt, r_prod[WIDTH-1:1]};

`ifdef MULT32_SIGNED_EN
    logic r_neg;

    assign w_load_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign w_load_b = b[WIDTH-1] ? (~b + 1'b1) : b;
    // Sign is applied on the same edge that enters DONE, so latency is
    // identical to the unsigned build.
    assign w_final  = r_neg ? (~w_step + 1'b1) : w_step;
`else
    assign w_load_a = a;
    assign w_load_b = b;
    assign w_final  = w_step;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        ready       = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (r_cnt == C_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: multiplicand, product shift register, iteration counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
`ifdef MULT32_SIGNED_EN
            r_neg   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_mcand <= w_load_a;
            r_prod  <= {{WIDTH{1'b0}}, w_load_b};
            r_cnt   <= '0;
`ifdef MULT32_SIGNED_EN
            r_neg   <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
        end else if (r_state == CALC) begin
            r_prod <= w_last ? w_final : w_step;
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    assign product = r_prod;

endmodule : mult32_seq
`default_nettype wire
